// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-addressed data memory that answers one CPU load/store at a time
//   after a fixed LATENCY wait. It accepts a request only when idle and
//   returns a one-cycle ready strobe carrying an error flag. Reset clears
//   the whole storage array.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit storage words
//   LATENCY     : wait cycles between accept and response (0..15)
//
// Ports
//   CLK   in   clock, all state on the rising edge
//   RST   in   synchronous active-high reset
//   mRD   in   load strobe
//   mWR   in   store strobe
//   addr  in   [31:0] byte address (word index = addr[31:2])
//   wdata in   [31:0] store data
//   rdata out  [31:0] registered load result, held between loads
//   ready out  one-cycle response strobe
//   busy  out  request in flight (WAIT or RESP)
//   err   out  response error flag, only meaningful with ready
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        mRD,
  input  logic        mWR,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        enter_resp;
  logic        req;

  logic        cap_rd, cap_wr;
  logic [31:0] cap_addr, cap_wdata;
  logic        err_q;

  logic        op_rd, op_wr;
  logic [31:0] op_addr, op_wdata;
  logic        bad;
  logic [AW-1:0] widx;

  // Words are stored exactly as presented on wdata, so byte addr+0 lives
  // in bits 31:24 (big-endian) without any lane swapping.
  logic [31:0] mem [DEPTH_WORDS];

  assign req = mRD | mWR;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic; enter_resp marks the edge that commits the access.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: if (req) begin
        if (LATENCY == 0) begin
          state_nx   = RESP;
          enter_resp = 1'b1;
        end else begin
          state_nx = WAIT;
          cnt_nx   = CNT_INIT;
        end
      end
      WAIT: if (cnt == 4'd0) begin
        state_nx   = RESP;
        enter_resp = 1'b1;
      end else begin
        cnt_nx = cnt - 4'd1;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ready = (state == RESP);
    busy  = (state != IDLE);
    err   = (state == RESP) & err_q;
  end

  // Request capture at accept; later input activity is ignored.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cap_rd    <= 1'b0;
      cap_wr    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (state == IDLE && req) begin
      cap_rd    <= mRD;
      cap_wr    <= mWR;
      cap_addr  <= addr;
      cap_wdata <= wdata;
    end
  end

  // With LATENCY=0 the commit edge is the accept edge, so the live inputs
  // are used there; otherwise the captured request.
  always_comb begin
    op_rd    = (state == IDLE) ? mRD   : cap_rd;
    op_wr    = (state == IDLE) ? mWR   : cap_wr;
    op_addr  = (state == IDLE) ? addr  : cap_addr;
    op_wdata = (state == IDLE) ? wdata : cap_wdata;
    bad      = (op_rd & op_wr) | (|op_addr[1:0]) |
               (op_addr[31:2] >= 30'(DEPTH_WORDS));
    widx     = op_addr[AW+1:2];
  end

  // Storage, load data and error flag. Only loads touch rdata; an errored
  // load returns zero, an errored store or dual strobe leaves it alone.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
      rdata <= '0;
      err_q <= 1'b0;
    end else if (enter_resp) begin
      err_q <= bad;
      if (op_wr && !bad) mem[widx] <= op_wdata;
      if (op_rd && !op_wr) rdata <= bad ? 32'd0 : mem[widx];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int NDUT = 2;
  localparam int LATS [NDUT] = '{2, 0};
  localparam int DEPTH = 64;

  logic        CLK = 1'b0;
  logic        RST, mRD, mWR;
  logic [31:0] addr, wdata;
  logic [31:0] rdata_o [NDUT];
  logic [NDUT-1:0] ready_o, busy_o, err_o;
  logic        done;

  always #5 CLK = ~CLK;

  // Same stimulus drives a LATENCY=2 and a LATENCY=0 instance.
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LATS[g])) u_dut (
      .CLK(CLK), .RST(RST), .mRD(mRD), .mWR(mWR), .addr(addr), .wdata(wdata),
      .rdata(rdata_o[g]), .ready(ready_o[g]), .busy(busy_o[g]), .err(err_o[g])
    );
  end

  typedef struct {
    int          dut;
    int          due;    // edge after which ready must be visible
    logic        err;
    logic        upd;    // response replaces rdata
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mem_m [NDUT][DEPTH];
  logic [31:0] rdata_m [NDUT];
  int          next_free [NDUT];
  int          edge_n;
  int          n_cmp, n_bad;

  function automatic int find_idx(input int d);
    for (int i = 0; i < sb.size(); i++) if (sb[i].dut == d) return i;
    return -1;
  endfunction

  // Reference model (posedge) and monitor (negedge) in one process.
  initial begin
    edge_n = 0; n_cmp = 0; n_bad = 0;
    for (int d = 0; d < NDUT; d++) begin
      next_free[d] = 0; rdata_m[d] = '0;
      for (int w = 0; w < DEPTH; w++) mem_m[d][w] = '0;
    end
    forever begin
      @(posedge CLK);
      edge_n++;
      for (int d = 0; d < NDUT; d++) begin
        if (RST) begin
          for (int w = 0; w < DEPTH; w++) mem_m[d][w] = '0;
          for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].dut == d) sb.delete(i);
          rdata_m[d]   = '0;
          next_free[d] = 0;
        end else if ((mRD || mWR) && edge_n >= next_free[d]) begin
          exp_t e;
          int   widx;
          logic bad;
          widx = int'(addr[31:2]);
          bad  = (mRD && mWR) || addr[1:0] != 2'b00 || widx >= DEPTH;
          e.dut   = d;
          e.due   = edge_n + LATS[d];
          e.err   = bad;
          e.upd   = mRD && !mWR;
          e.rdata = bad ? 32'd0 : mem_m[d][widx];
          if (mWR && !mRD && !bad) mem_m[d][widx] = wdata;
          sb.push_back(e);
          next_free[d] = edge_n + LATS[d] + 2;
        end
      end

      @(negedge CLK);
      for (int d = 0; d < NDUT; d++) begin
        int   idx;
        logic exp_rdy;
        idx = find_idx(d);
        if (idx >= 0 && sb[idx].due < edge_n) begin
          n_cmp++; n_bad++;
          $display("FAIL missed_ready dut%0d edge %0d: no response, required at edge %0d",
                   d, edge_n, sb[idx].due);
          sb.delete(idx);
          idx = find_idx(d);
        end
        exp_rdy = (idx >= 0) && (sb[idx].due == edge_n);
        n_cmp++;
        if (ready_o[d] !== exp_rdy) begin
          n_bad++;
          $display("FAIL ready dut%0d edge %0d: got %b required %b", d, edge_n, ready_o[d], exp_rdy);
        end
        if (exp_rdy) begin
          n_cmp++;
          if (err_o[d] !== sb[idx].err) begin
            n_bad++;
            $display("FAIL err dut%0d edge %0d: got %b required %b", d, edge_n, err_o[d], sb[idx].err);
          end
          if (sb[idx].upd) rdata_m[d] = sb[idx].rdata;
          sb.delete(idx);
        end else begin
          n_cmp++;
          if (err_o[d] !== 1'b0) begin
            n_bad++;
            $display("FAIL err_idle dut%0d edge %0d: got %b required 0", d, edge_n, err_o[d]);
          end
        end
        n_cmp++;
        if (busy_o[d] !== (edge_n <= next_free[d] - 2)) begin
          n_bad++;
          $display("FAIL busy dut%0d edge %0d: got %b required %b", d, edge_n, busy_o[d],
                   (edge_n <= next_free[d] - 2));
        end
        n_cmp++;
        if (rdata_o[d] !== rdata_m[d]) begin
          n_bad++;
          $display("FAIL rdata dut%0d edge %0d: got %h required %h", d, edge_n, rdata_o[d], rdata_m[d]);
        end
      end

      if (edge_n > 20000) begin
        $display("FAIL timeout edge %0d: stimulus never completed", edge_n);
        $fatal(1, "timeout");
      end
      if (done) begin
        foreach (sb[i]) begin
          n_cmp++; n_bad++;
          $display("FAIL leftover dut%0d: response due at edge %0d never seen", sb[i].dut, sb[i].due);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  // Single-cycle request pulse, then enough idle time for both instances.
  task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    mRD = rd; mWR = wr; addr = a; wdata = d;
    @(negedge CLK);
    mRD = 1'b0; mWR = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(3))
      0, 1:    return {22'd0, 4'($urandom_range(15)), 2'b00} + 32'({$urandom_range(3), 6'd0});
      2:       return {24'd0, 6'($urandom_range(63)), 2'($urandom_range(1, 3))};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    RST = 1'b1; mRD = 1'b0; mWR = 1'b0; addr = '0; wdata = '0; done = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    req(1, 0, 32'h4, 32'h0);               // load after reset returns 0
    req(0, 1, 32'h8, 32'h1234_5678);       // store, then read it back
    req(1, 0, 32'h8, 32'h0);
    req(0, 1, 32'h4, 32'hA5A5_0004);       // seed word 1
    req(0, 1, 32'h6, 32'hFFFF_FFFF);       // misaligned store dropped
    req(1, 0, 32'h4, 32'h0);
    req(1, 0, 32'h100, 32'h0);             // word 64: out of range
    req(1, 1, 32'h8, 32'hBAD0_BAD0);       // dual strobe error
    req(1, 0, 32'h8, 32'h0);

    // Second pulse while the first request is still in flight
    mRD = 1'b1; addr = 32'hC;
    @(negedge CLK);
    mRD = 1'b0;
    @(negedge CLK);
    mRD = 1'b1; addr = 32'h10;
    @(negedge CLK);
    mRD = 1'b0;
    repeat (5) @(negedge CLK);

    // Request held high: re-accepted every LATENCY+2 edges
    mRD = 1'b1; addr = 32'h8;
    repeat (12) @(negedge CLK);
    mRD = 1'b0;
    repeat (5) @(negedge CLK);

    // Reset while a store waits
    mWR = 1'b1; addr = 32'h0; wdata = 32'hDEAD_BEEF;
    @(negedge CLK);
    mWR = 1'b0; RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    req(1, 0, 32'h0, 32'h0);

    // Random traffic, including strobes while busy and sporadic resets
    for (int c = 0; c < 1500; c++) begin
      RST   = ($urandom_range(199) == 0);
      mRD   = ($urandom_range(2) == 0);
      mWR   = ($urandom_range(2) == 0);
      addr  = rand_addr();
      wdata = $urandom;
      @(negedge CLK);
    end
    RST = 1'b0; mRD = 1'b0; mWR = 1'b0;
    repeat (8) @(negedge CLK);
    done = 1'b1;
  end

endmodule
